// File: rtl/serial_add_ctrl_pkg.sv
// rtl/serial_add_ctrl_pkg.sv - shared state encoding and default width for the serial adder
package serial_add_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - request/result bundle between a requester and the serial adder
interface serial_add_ctrl_if #(
  parameter int WIDTH = serial_add_ctrl_pkg::DEFAULT_WIDTH
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_add_ctrl_fa_cell.sv
// rtl/serial_add_ctrl_fa_cell.sv - gate-level 1-bit full adder shared by every bit position
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  wire w_ab_x;
  wire w_ab_a;
  wire w_cx_a;

  xor g_x0 (w_ab_x, a, b);
  xor g_x1 (s, w_ab_x, ci);
  and g_a0 (w_ab_a, a, b);
  and g_a1 (w_cx_a, w_ab_x, ci);
  or  g_o0 (co, w_ab_a, w_cx_a);
endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add/subtract, LSB first, one full-adder cell per operation
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  serial_add_ctrl_if.slave bus
);
  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_c_msb;
  logic             w_s;
  logic             w_co;
  logic             w_accept;
  logic             w_last;

  assign w_accept = (r_state == IDLE) && bus.start;
  assign w_last   = (r_state == RUN) && (r_cnt == LAST);

  fa_cell u_fa (
    .a  (r_a_sr[0]),
    .b  (r_b_sr[0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = RUN;
      RUN:     if (r_cnt == LAST) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1: invert B at capture and seed the carry with 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_c_msb <= 1'b0;
    end else if (w_accept) begin
      r_a_sr  <= bus.a;
      r_b_sr  <= bus.sub ? ~bus.b : bus.b;
      r_carry <= bus.sub ? 1'b1 : bus.cin;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_sum   <= {w_s, r_sum[WIDTH-1:1]};
      r_a_sr  <= {1'b0, r_a_sr[WIDTH-1:1]};
      r_b_sr  <= {1'b0, r_b_sr[WIDTH-1:1]};
      r_carry <= w_co;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) r_c_msb <= r_carry;
    end
  end

  // r_carry holds the MSB carry-out once the last bit is done.
  assign bus.busy = (r_state == RUN) || (r_state == DONE);
  assign bus.done = (r_state == DONE);
  assign bus.sum  = r_sum;
  assign bus.cout = r_carry;
  assign bus.ovf  = r_c_msb ^ r_carry;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed self-checking bench for serial_add_ctrl at WIDTH=8
module tb_serial_add_ctrl;
  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  serial_add_ctrl_if #(.WIDTH(8)) bus ();

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] b2b_a    [3] = '{8'h01, 8'hFF, 8'h80};
  logic [7:0] b2b_b    [3] = '{8'h02, 8'h01, 8'h01};
  logic       b2b_sub  [3] = '{1'b0, 1'b0, 1'b1};
  logic [7:0] b2b_sum  [3] = '{8'h03, 8'h00, 8'h7F};
  logic       b2b_cout [3] = '{1'b0, 1'b1, 1'b1};
  logic       b2b_ovf  [3] = '{1'b0, 1'b0, 1'b1};

  // Drive one request and wait for done; latency counts edges from the accepting edge.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic sub, output int lat);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub; bus.start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) bus.start = 1'b0;
    end while (!bus.done && lat < 30);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    repeat (3) @(negedge clk);
    n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else n_pass++;
    n_total++; if (bus.done !== 1'b0) $display("FAIL reset_done got=%b exp=0", bus.done); else n_pass++;
    n_total++; if (bus.sum !== 8'h00) $display("FAIL reset_sum got=%h exp=00", bus.sum); else n_pass++;
    n_total++; if (bus.cout !== 1'b0) $display("FAIL reset_cout got=%b exp=0", bus.cout); else n_pass++;
    n_total++; if (bus.ovf !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", bus.ovf); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    int lat;
    logic [7:0] held;
    run_op(8'h3C, 8'h0F, 1'b0, 1'b0, lat);
    n_total++; if (lat !== 9) $display("FAIL add1_latency got=%0d exp=9", lat); else n_pass++;
    n_total++; if (bus.sum !== 8'h4B) $display("FAIL add1_sum got=%h exp=4b", bus.sum); else n_pass++;
    n_total++; if (bus.cout !== 1'b0) $display("FAIL add1_cout got=%b exp=0", bus.cout); else n_pass++;
    n_total++; if (bus.ovf !== 1'b0) $display("FAIL add1_ovf got=%b exp=0", bus.ovf); else n_pass++;
    held = bus.sum;
    @(negedge clk);
    n_total++; if (bus.done !== 1'b0) $display("FAIL done_pulse_width got=%b exp=0", bus.done); else n_pass++;
    repeat (3) @(negedge clk);
    n_total++; if (bus.sum !== 8'h4B) $display("FAIL add1_hold_sum got=%h exp=4b", bus.sum); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL idle_busy got=%b exp=0", bus.busy); else n_pass++;

    run_op(8'hFF, 8'h01, 1'b1, 1'b0, lat);
    n_total++; if (bus.sum !== 8'h01) $display("FAIL add2_sum got=%h exp=01", bus.sum); else n_pass++;
    n_total++; if (bus.cout !== 1'b1) $display("FAIL add2_cout got=%b exp=1", bus.cout); else n_pass++;
    n_total++; if (bus.ovf !== 1'b0) $display("FAIL add2_ovf got=%b exp=0", bus.ovf); else n_pass++;

    run_op(8'h7F, 8'h01, 1'b0, 1'b0, lat);
    n_total++; if (bus.sum !== 8'h80) $display("FAIL add3_sum got=%h exp=80", bus.sum); else n_pass++;
    n_total++; if (bus.cout !== 1'b0) $display("FAIL add3_cout got=%b exp=0", bus.cout); else n_pass++;
    n_total++; if (bus.ovf !== 1'b1) $display("FAIL add3_ovf got=%b exp=1", bus.ovf); else n_pass++;
    repeat (2) @(negedge clk);
    n_total++; if (bus.ovf !== 1'b1) $display("FAIL add3_hold_ovf got=%b exp=1", bus.ovf); else n_pass++;
  endtask

  task automatic test_sub();
    int lat;
    run_op(8'h05, 8'h09, 1'b0, 1'b1, lat);
    n_total++; if (bus.sum !== 8'hFC) $display("FAIL sub1_sum got=%h exp=fc", bus.sum); else n_pass++;
    n_total++; if (bus.cout !== 1'b0) $display("FAIL sub1_cout got=%b exp=0", bus.cout); else n_pass++;
    n_total++; if (bus.ovf !== 1'b0) $display("FAIL sub1_ovf got=%b exp=0", bus.ovf); else n_pass++;

    // cin must be ignored for subtraction
    run_op(8'h80, 8'h01, 1'b1, 1'b1, lat);
    n_total++; if (bus.sum !== 8'h7F) $display("FAIL sub2_sum got=%h exp=7f", bus.sum); else n_pass++;
    n_total++; if (bus.cout !== 1'b1) $display("FAIL sub2_cout got=%b exp=1", bus.cout); else n_pass++;
    n_total++; if (bus.ovf !== 1'b1) $display("FAIL sub2_ovf got=%b exp=1", bus.ovf); else n_pass++;
  endtask

  task automatic test_start_ignored();
    int lat;
    @(negedge clk);
    bus.a = 8'h3C; bus.b = 8'h0F; bus.cin = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) bus.start = 1'b0;
      if (lat == 3) begin
        bus.a = 8'h11; bus.b = 8'h22; bus.cin = 1'b1; bus.sub = 1'b1; bus.start = 1'b1;
      end
      if (lat == 4) bus.start = 1'b0;
    end while (!bus.done && lat < 30);
    n_total++; if (lat !== 9) $display("FAIL ignore_latency got=%0d exp=9", lat); else n_pass++;
    n_total++; if (bus.sum !== 8'h4B) $display("FAIL ignore_sum got=%h exp=4b", bus.sum); else n_pass++;
    n_total++; if (bus.cout !== 1'b0) $display("FAIL ignore_cout got=%b exp=0", bus.cout); else n_pass++;
    @(negedge clk);
    n_total++; if (bus.busy !== 1'b0) $display("FAIL ignore_no_requeue got=%b exp=0", bus.busy); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int seen_done;
    @(negedge clk);
    bus.a = 8'h3C; bus.b = 8'h0F; bus.cin = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", bus.busy); else n_pass++;
    n_total++; if (bus.sum !== 8'h00) $display("FAIL midrst_sum got=%h exp=00", bus.sum); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen_done++;
    end
    n_total++; if (seen_done !== 0) $display("FAIL midrst_no_done got=%0d exp=0", seen_done); else n_pass++;
    run_op(8'h10, 8'h20, 1'b0, 1'b0, lat);
    n_total++; if (lat !== 9) $display("FAIL midrst_latency got=%0d exp=9", lat); else n_pass++;
    n_total++; if (bus.sum !== 8'h30) $display("FAIL midrst_sum2 got=%h exp=30", bus.sum); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int k;
    int cyc;
    int last_cyc;
    k = 0; cyc = 0; last_cyc = 0;
    @(negedge clk);
    bus.a = b2b_a[0]; bus.b = b2b_b[0]; bus.sub = b2b_sub[0]; bus.cin = 1'b0; bus.start = 1'b1;
    while (k < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        n_total++; if (bus.sum !== b2b_sum[k]) $display("FAIL b2b%0d_sum got=%h exp=%h", k, bus.sum, b2b_sum[k]); else n_pass++;
        n_total++; if (bus.cout !== b2b_cout[k]) $display("FAIL b2b%0d_cout got=%b exp=%b", k, bus.cout, b2b_cout[k]); else n_pass++;
        n_total++; if (bus.ovf !== b2b_ovf[k]) $display("FAIL b2b%0d_ovf got=%b exp=%b", k, bus.ovf, b2b_ovf[k]); else n_pass++;
        n_total++;
        if (cyc - last_cyc !== ((k == 0) ? 9 : 10))
          $display("FAIL b2b%0d_spacing got=%0d exp=%0d", k, cyc - last_cyc, (k == 0) ? 9 : 10);
        else n_pass++;
        last_cyc = cyc;
        k++;
        if (k < 3) begin
          bus.a = b2b_a[k]; bus.b = b2b_b[k]; bus.sub = b2b_sub[k];
        end else begin
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    n_total++; if (k !== 3) $display("FAIL b2b_count got=%0d exp=3", k); else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_add();
    test_sub();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
